// File: rtl/mini_fir_cfg_pkg.sv
// Shared types and constants for the mini FIR configuration front-end.
// Checksum option: define MINI_FIR_CFG_CSUM_EN.
package mini_fir_cfg_pkg;

  localparam int DATA_W    = 8;
  localparam int COEFF_W   = 8;
  localparam int NTAP_DEF  = 7;
  localparam int FLUSH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_FLUSH  = 2'd3
  } state_e;

endpackage

// File: rtl/mini_fir_coef_bank.sv
// Shadow/active coefficient bank: byte-wide shadow writes, atomic commit to the
// active bank that feeds the datapath.
module mini_fir_coef_bank
  import mini_fir_cfg_pkg::*;
#(
  parameter int NTAP  = NTAP_DEF,
  parameter int IDX_W = $clog2(NTAP_DEF + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_we,
  input  logic [IDX_W-1:0]        i_idx,
  input  logic [COEFF_W-1:0]      i_data,
  input  logic                    i_commit,
  output logic [COEFF_W*NTAP-1:0] o_active_flat
);

  logic [COEFF_W-1:0] shadow_q [NTAP];
  logic [COEFF_W-1:0] active_q [NTAP];

  // NOTE: both banks are reset on purpose: the datapath must see all-zero
  // coefficients after reset, so these are registers, not a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAP; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NTAP; k++) begin
        if (i_we && (i_idx == IDX_W'(k))) shadow_q[k] <= i_data;
        if (i_commit)                     active_q[k] <= shadow_q[k];
      end
    end
  end

  for (genvar k = 0; k < NTAP; k++) begin : g_flat
    assign o_active_flat[COEFF_W*k +: COEFF_W] = active_q[k];
  end

endmodule

// File: rtl/mini_fir_cfg.sv
// Coefficient loader, commit/flush sequencer and sample register for the FIR.
// Optional checksum byte after the coefficients: define MINI_FIR_CFG_CSUM_EN.
module mini_fir_cfg
  import mini_fir_cfg_pkg::*;
#(
  parameter int NTAP      = NTAP_DEF,
  parameter int FLUSH_CYC = FLUSH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cfg_start,
  input  logic                    i_cfg_valid,
  output logic                    o_cfg_ready,
  input  logic [COEFF_W-1:0]      i_cfg_data,
  output logic                    o_cfg_done,
  output logic                    o_cfg_err,
  output logic                    o_busy,
  output logic [COEFF_W*NTAP-1:0] o_coeff_flat,
  input  logic                    i_smp_valid,
  output logic                    o_smp_ready,
  input  logic [DATA_W-1:0]       i_smp_data,
  output logic [DATA_W-1:0]       o_din
);

  localparam int IDX_W = $clog2(NTAP + 1);
  localparam int CNT_W = $clog2(FLUSH_CYC + 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  din_q;
  logic               done_q;
  logic               smp_open;
  logic               cfg_hs;
  logic               bank_we;

  assign smp_open = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  // A start in the same cycle as a handshake wins; the byte is dropped.
  assign cfg_hs   = (state_q == ST_LOAD) && i_cfg_valid && !i_cfg_start;
  assign bank_we  = cfg_hs && (idx_q < IDX_W'(NTAP));

  assign o_cfg_ready = (state_q == ST_LOAD);
  assign o_smp_ready = smp_open;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_cfg_done  = done_q;
  assign o_din       = din_q;

`ifdef MINI_FIR_CFG_CSUM_EN
  logic [COEFF_W-1:0] csum_q;
  logic               err_q;
  assign o_cfg_err = err_q;
`else
  assign o_cfg_err = 1'b0;
`endif

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
`ifdef MINI_FIR_CFG_CSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MINI_FIR_CFG_CSUM_EN
      err_q  <= 1'b0;
`endif
      // Bubbles and closed windows feed zeros into the datapath.
      din_q <= (smp_open && i_smp_valid) ? i_smp_data : '0;

      case (state_q)
        ST_IDLE: begin
          if (i_cfg_start) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
`ifdef MINI_FIR_CFG_CSUM_EN
            csum_q  <= '0;
`endif
          end
        end

        ST_LOAD: begin
          if (i_cfg_start) begin
            idx_q   <= '0;
`ifdef MINI_FIR_CFG_CSUM_EN
            csum_q  <= '0;
`endif
          end else if (cfg_hs) begin
`ifdef MINI_FIR_CFG_CSUM_EN
            if (idx_q != IDX_W'(NTAP)) begin
              idx_q  <= idx_q + 1'b1;
              csum_q <= csum_q + i_cfg_data;
            end else if (i_cfg_data == csum_q) begin
              state_q <= ST_COMMIT;
            end else begin
              state_q <= ST_IDLE;
              err_q   <= 1'b1;
            end
`else
            if (idx_q == IDX_W'(NTAP - 1)) state_q <= ST_COMMIT;
            else                           idx_q   <= idx_q + 1'b1;
`endif
          end
        end

        ST_COMMIT: begin
          cnt_q   <= '0;
          state_q <= ST_FLUSH;
        end

        ST_FLUSH: begin
          if (cnt_q == CNT_W'(FLUSH_CYC - 1)) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  mini_fir_coef_bank #(
    .NTAP  (NTAP),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk           (clk),
    .rst           (rst),
    .i_we          (bank_we),
    .i_idx         (idx_q),
    .i_data        (i_cfg_data),
    .i_commit      (state_q == ST_COMMIT),
    .o_active_flat (o_coeff_flat)
  );

endmodule

// File: tb/tb_mini_fir_cfg.sv
// Directed self-checking bench for mini_fir_cfg; follows MINI_FIR_CFG_CSUM_EN
// by appending the checksum byte and running the checksum cases.
module tb_mini_fir_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cfg_start;
  logic        i_cfg_valid;
  logic        o_cfg_ready;
  logic [7:0]  i_cfg_data;
  logic        o_cfg_done;
  logic        o_cfg_err;
  logic        o_busy;
  logic [55:0] o_coeff_flat;
  logic        i_smp_valid;
  logic        o_smp_ready;
  logic [7:0]  i_smp_data;
  logic [7:0]  o_din;

  int   errors = 0;
  int   checks = 0;
  logic stream_chk = 1'b0;

  localparam logic [55:0] COEF_A = 56'h07_06_05_04_03_02_01;
  localparam logic [55:0] COEF_B = 56'h0F_0E_0D_0C_0B_0A_09;
  localparam logic [55:0] COEF_C = 56'h17_16_15_14_13_12_11;

  mini_fir_cfg dut (
    .clk          (clk),
    .rst          (rst),
    .i_cfg_start  (i_cfg_start),
    .i_cfg_valid  (i_cfg_valid),
    .o_cfg_ready  (o_cfg_ready),
    .i_cfg_data   (i_cfg_data),
    .o_cfg_done   (o_cfg_done),
    .o_cfg_err    (o_cfg_err),
    .o_busy       (o_busy),
    .o_coeff_flat (o_coeff_flat),
    .i_smp_valid  (i_smp_valid),
    .o_smp_ready  (o_smp_ready),
    .i_smp_data   (i_smp_data),
    .o_din        (o_din)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge. While the
  // sample stream is being checked, the pre-edge sample must appear on o_din.
  task automatic tick();
    logic       sv;
    logic [7:0] sd;
    sv = i_smp_valid;
    sd = i_smp_data;
    @(posedge clk);
    #1;
    if (stream_chk) begin
      check("din_stream", o_din, sv ? sd : 8'd0);
      i_smp_data = sd + 8'd3;
    end
  endtask

  task automatic cfg_start();
    i_cfg_start = 1'b1;
    tick();
    i_cfg_start = 1'b0;
    check("start_busy", o_busy, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    if (gap) begin
      i_cfg_valid = 1'b0;
      tick();
    end
    check("cfg_ready_load", o_cfg_ready, 1'b1);
    if (stream_chk) check("smp_ready_load", o_smp_ready, 1'b1);
    i_cfg_valid = 1'b1;
    i_cfg_data  = b;
    tick();
    i_cfg_valid = 1'b0;
  endtask

  task automatic send_coeffs(input logic [55:0] c, input bit gap);
    logic [7:0] sum;
    sum = 8'd0;
    for (int k = 0; k < 7; k++) begin
      send_byte(c[8*k +: 8], gap);
      sum = sum + c[8*k +: 8];
    end
`ifdef MINI_FIR_CFG_CSUM_EN
    send_byte(sum, gap);
`endif
  endtask

  // Called in the COMMIT cycle: 1 COMMIT + 8 FLUSH cycles with ready low.
  task automatic expect_commit(input logic [55:0] old_c, input logic [55:0] new_c);
    int low;
    check("commit_smp_ready", o_smp_ready, 1'b0);
    check("commit_coeff_held", o_coeff_flat, old_c);
    check("commit_busy", o_busy, 1'b1);
    low = 1;
    tick();
    check("flush_coeff_new", o_coeff_flat, new_c);
    while (o_smp_ready == 1'b0 && low < 40) begin
      check("flush_din_zero", o_din, 8'd0);
      check("flush_no_done", o_cfg_done, 1'b0);
      low++;
      tick();
    end
    check("flush_len", low, 9);
    check("done_pulse", o_cfg_done, 1'b1);
    check("done_idle_busy", o_busy, 1'b0);
    check("no_err", o_cfg_err, 1'b0);
    tick();
    check("done_once", o_cfg_done, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    i_cfg_start = 1'b0;
    i_cfg_valid = 1'b0;
    i_cfg_data  = 8'd0;
    i_smp_valid = 1'b0;
    i_smp_data  = 8'd0;
    tick();
    tick();
    check("rst_din", o_din, 8'd0);
    check("rst_cfg_ready", o_cfg_ready, 1'b0);
    check("rst_smp_ready", o_smp_ready, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_cfg_done, 1'b0);
    check("rst_err", o_cfg_err, 1'b0);
    check("rst_coeff", o_coeff_flat, 56'd0);
    rst = 1'b0;

    // Samples pass with one cycle of latency; a bubble becomes zero.
    i_smp_valid = 1'b1;
    i_smp_data  = 8'd10; tick(); check("smp_10", o_din, 8'd10);
    i_smp_data  = 8'd20; tick(); check("smp_20", o_din, 8'd20);
    i_smp_data  = 8'd30; tick(); check("smp_30", o_din, 8'd30);
    i_smp_valid = 1'b0;  tick(); check("smp_bubble", o_din, 8'd0);
    check("smp_coeff_zero", o_coeff_flat, 56'd0);
    check("smp_busy", o_busy, 1'b0);

    // Back-to-back load of 1..7.
    cfg_start();
    send_coeffs(COEF_A, 1'b0);
    expect_commit(56'd0, COEF_A);

    // Gapped load while samples stream through.
    i_smp_valid = 1'b1;
    i_smp_data  = 8'd50;
    stream_chk  = 1'b1;
    cfg_start();
    send_coeffs(COEF_A, 1'b1);
    stream_chk  = 1'b0;
    expect_commit(COEF_A, COEF_A);
    i_smp_valid = 1'b0;

    // Restart after three bytes; the restart collides with a handshake.
    cfg_start();
    send_byte(8'd100, 1'b0);
    send_byte(8'd101, 1'b0);
    send_byte(8'd102, 1'b0);
    i_cfg_start = 1'b1;
    i_cfg_valid = 1'b1;
    i_cfg_data  = 8'd99;
    tick();
    i_cfg_start = 1'b0;
    i_cfg_valid = 1'b0;
    check("restart_still_load", o_cfg_ready, 1'b1);
    send_coeffs(COEF_B, 1'b0);
    expect_commit(COEF_A, COEF_B);

`ifdef MINI_FIR_CFG_CSUM_EN
    // Bad checksum (27 instead of 28): error pulse, no commit, no flush.
    cfg_start();
    for (int k = 0; k < 7; k++) send_byte(COEF_A[8*k +: 8], 1'b0);
    send_byte(8'd27, 1'b0);
    check("csum_err_pulse", o_cfg_err, 1'b1);
    check("csum_err_coeff", o_coeff_flat, COEF_B);
    check("csum_err_smp_ready", o_smp_ready, 1'b1);
    check("csum_err_busy", o_busy, 1'b0);
    check("csum_err_no_done", o_cfg_done, 1'b0);
    tick();
    check("csum_err_once", o_cfg_err, 1'b0);
    check("csum_err_coeff_hold", o_coeff_flat, COEF_B);
    // Good checksum 28 commits.
    cfg_start();
    send_coeffs(COEF_A, 1'b0);
    expect_commit(COEF_B, COEF_A);
    cfg_start();
    send_coeffs(COEF_B, 1'b0);
    expect_commit(COEF_A, COEF_B);
`endif

    // Reset in the middle of a flush window.
    cfg_start();
    send_coeffs(COEF_C, 1'b0);
    tick();
    tick();
    tick();
    check("pre_rst_flushing", o_smp_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_din", o_din, 8'd0);
    check("mid_rst_cfg_ready", o_cfg_ready, 1'b0);
    check("mid_rst_smp_ready", o_smp_ready, 1'b1);
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_done", o_cfg_done, 1'b0);
    check("mid_rst_err", o_cfg_err, 1'b0);
    check("mid_rst_coeff", o_coeff_flat, 56'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_rst_no_done", o_cfg_done, 1'b0);
      check("post_rst_idle", o_busy, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mini_fir_cfg.md
Name: mini_fir_cfg

Overview:
- Front-end controller for the 7-tap transposed FIR datapath.
- Loads coefficient bytes from a valid/ready configuration stream into a shadow bank, then commits them atomically to the active bank that drives the datapath coefficient inputs.
- Supplies the datapath sample input from a valid/ready sample stream.
- Stuffs zeros into the datapath for a fixed flush window after each commit, so no output mixes old and new coefficients.

Parameters:
- NTAP, 7, number of coefficients (datapath taps).
- FLUSH_CYC, 8, cycles of zero input after commit (NTAP+1 covers MAC chain plus output register).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- i_cfg_start  input  1  begin (or restart) a coefficient load.
- i_cfg_valid  input  1  config byte valid.
- o_cfg_ready  output  1  config byte accepted when valid&ready.
- i_cfg_data  input  8  coefficient byte, tap 0 first.
- o_cfg_done  output  1  one-cycle pulse when the flush window ends.
- o_cfg_err  output  1  one-cycle pulse on checksum mismatch (optional feature only).
- o_busy  output  1  high whenever state is not IDLE.
- o_coeff_flat  output  8*NTAP  active coefficients; tap k at bits [8k+7:8k].
- i_smp_valid  input  1  sample valid.
- o_smp_ready  output  1  sample accepted when valid&ready.
- i_smp_data  input  8  unsigned sample.
- o_din  output  8  registered sample to the datapath.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) sets:
  - state IDLE, tap index 0, flush count 0;
  - shadow and active banks all 0, so o_coeff_flat=0;
  - o_din=0, o_cfg_ready=0, o_smp_ready=1, o_busy=0, o_cfg_done=0, o_cfg_err=0.
- Reset mid-load or mid-flush discards everything and returns to the reset state.
- FSM states: IDLE, LOAD, COMMIT, FLUSH.
- IDLE:
  - i_cfg_start -> LOAD, index=0.
- LOAD:
  - o_cfg_ready=1.
  - Each handshake writes shadow[index]=i_cfg_data, then index++.
  - Handshake with index==NTAP-1 -> COMMIT.
  - i_cfg_start in LOAD resets index to 0; partial shadow contents are left unused and overwritten.
  - If i_cfg_start and a handshake occur in the same cycle, start wins and the byte is dropped.
- COMMIT (1 cycle):
  - active<=shadow (all taps at one edge); o_coeff_flat changes on exit from COMMIT.
  - Flush count=0, -> FLUSH.
- FLUSH:
  - o_smp_ready=0, o_din=0 every cycle.
  - After FLUSH_CYC cycles -> IDLE, with o_cfg_done=1 in the first IDLE cycle.
- i_cfg_start is ignored in COMMIT and FLUSH.
- Samples, IDLE and LOAD:
  - o_smp_ready=1.
  - On valid, o_din<=i_smp_data (1-cycle latency).
  - With no valid, o_din<=0 (bubble = zero).
  - Samples flow with the old coefficients throughout LOAD.
- COMMIT: o_smp_ready=0, o_din<=0.
- Widths: index is clog2(NTAP+1) bits; flush count is clog2(FLUSH_CYC+1) bits; no arithmetic on data.

Optional Feature:
- Macro: MINI_FIR_CFG_CSUM_EN.
- Defined:
  - After the NTAP coefficients, LOAD accepts one extra checksum byte, which must equal the mod-256 sum of the coefficients.
  - Match -> COMMIT.
  - Mismatch -> IDLE without commit; active bank unchanged, o_cfg_err pulses 1 cycle, no flush, no o_cfg_done.
- Undefined:
  - No checksum byte; the last coefficient goes straight to COMMIT.
  - o_cfg_err is tied 0.

Decomposition:
- Shared header mini_fir_defs.vh:
  - state encodings (IDLE=0, LOAD=1, COMMIT=2, FLUSH=3);
  - DATA_W=8, COEFF_W=8, default NTAP=7.
- One natural sub-module, mini_fir_coef_bank:
  - shadow write port (index, data, we), commit strobe, flat active output.
- FSM, flush counter and sample register stay in mini_fir_cfg.

Test Plan:
- Reset, then samples 10,20,30 valid on consecutive cycles -> o_din 10,20,30 one cycle later; o_coeff_flat=0; o_busy=0.
- Start, load 1,2,3,4,5,6,7 back-to-back:
  - o_coeff_flat changes from 0 only after the COMMIT cycle, tap0=1 and tap6=7;
  - o_smp_ready low for 9 cycles (COMMIT+8 FLUSH) with o_din=0;
  - o_cfg_done pulses once.
- Load with i_cfg_valid toggled every other cycle, samples streaming -> samples pass unchanged during LOAD; result as previous.
- Start, 3 bytes, start again, then 7 bytes 9..15 -> active = 9..15; the first 3 bytes never appear.
- Assert rst during FLUSH -> next cycle all outputs at reset values; o_coeff_flat=0; no o_cfg_done.
- With MINI_FIR_CFG_CSUM_EN:
  - bytes 1..7 then 28 -> commit;
  - bytes 1..7 then 27 -> o_cfg_err pulse, coefficients unchanged, o_smp_ready stays 1.
